// File: rtl/rover_pkg.sv
// Shared types and helpers for the rover drive path: FSM states, command widths
// and the single-step duty slew function.
package rover_pkg;

  localparam int DUTY_W = 12;
  localparam int DIR_W  = 4;
  localparam logic [DIR_W-1:0] DIR_STOP = 4'b0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FOLLOW = 3'd1,
    IR_RST = 3'd2,
    IR_RUN = 3'd3,
    FAULT  = 3'd4
  } seqState_t;

  // Moves cur toward tgt by at most step, landing exactly on tgt (no overshoot/wrap).
  function automatic logic [DUTY_W-1:0] slewStep(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] tgt,
                                                 input logic [DUTY_W:0]   step);
    logic [DUTY_W-1:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return ({1'b0, diff} > step) ? cur + step[DUTY_W-1:0] : tgt;
    end
    diff = cur - tgt;
    return ({1'b0, diff} > step) ? cur - step[DUTY_W-1:0] : tgt;
  endfunction

endpackage

// File: rtl/motor_slew.sv
// Duty slew limiter and direction-reversal dead time in front of the H-bridge.
// Duties only move on the free-running slew tick; Direction only changes with both duties at 0.
module motor_slew
  import rover_pkg::*;
#(
  parameter int RAMP_DIV    = 4,
  parameter int RAMP_STEP   = 256,
  parameter int DEAD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIR_W-1:0]  tgt_dir,
  input  logic [DUTY_W-1:0] tgt_duty_a,
  input  logic [DUTY_W-1:0] tgt_duty_b,
  output logic [DIR_W-1:0]  Direction,
  output logic [DUTY_W-1:0] DutyA,
  output logic [DUTY_W-1:0] DutyB
);

  localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [DUTY_W:0] STEP = (DUTY_W + 1)'(RAMP_STEP);

  logic [TICK_W-1:0] tickCnt;
  logic [DEAD_W-1:0] deadCnt;
  logic              tick;
  logic              reversing;
  logic              dutiesZero;

  assign tick       = (tickCnt == TICK_W'(RAMP_DIV - 1));
  assign reversing  = (tgt_dir != Direction);
  assign dutiesZero = (DutyA == '0) && (DutyB == '0);

  // Leaving DIR_STOP needs no dead time because the bridge was not being driven.
  always_ff @(posedge clk) begin
    if (reset) begin
      tickCnt   <= '0;
      deadCnt   <= '0;
      Direction <= DIR_STOP;
      DutyA     <= '0;
      DutyB     <= '0;
    end else begin
      tickCnt <= tick ? '0 : tickCnt + 1'b1;
      if (!reversing) begin
        deadCnt <= '0;
        if (tick) begin
          DutyA <= slewStep(DutyA, tgt_duty_a, STEP);
          DutyB <= slewStep(DutyB, tgt_duty_b, STEP);
        end
      end else if (!dutiesZero) begin
        deadCnt <= '0;
        if (tick) begin
          DutyA <= slewStep(DutyA, '0, STEP);
          DutyB <= slewStep(DutyB, '0, STEP);
        end
      end else if (Direction == DIR_STOP) begin
        if (tick) Direction <= tgt_dir;
      end else if (deadCnt == DEAD_W'(DEAD_CYCLES - 1)) begin
        Direction <= tgt_dir;
        deadCnt   <= '0;
      end else begin
        deadCnt <= deadCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/drive_sequencer.sv
// Rover motion scheduler: picks line-follower or IR-module commands, runs the IR module
// handshake, detects timeout/lost-line faults, and feeds the slew/dead-time stage.
module drive_sequencer
  import rover_pkg::*;
#(
  parameter int IR_DEBOUNCE = 4,
  parameter int IR_TIMEOUT  = 1000,
  parameter int LOST_LIMIT  = 50,
  parameter int RAMP_DIV    = 4,
  parameter int RAMP_STEP   = 256,
  parameter int DEAD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        IPS,
  input  logic              IR,
  input  logic [DIR_W-1:0]  lf_dir,
  input  logic [DUTY_W-1:0] lf_duty_a,
  input  logic [DUTY_W-1:0] lf_duty_b,
  input  logic [DIR_W-1:0]  ir_dir,
  input  logic [DUTY_W-1:0] ir_duty_a,
  input  logic [DUTY_W-1:0] ir_duty_b,
  input  logic              IRModuleDone,
  output logic [DIR_W-1:0]  Direction,
  output logic [DUTY_W-1:0] DutyA,
  output logic [DUTY_W-1:0] DutyB,
  output logic              EnableIRModule,
  output logic              ResetIRModule,
  output logic [2:0]        state,
  output logic              fault
);

  seqState_t         curState;
  logic [15:0]       irCnt;
  logic [15:0]       lostCnt;
  logic [15:0]       runCnt;
  logic [DIR_W-1:0]  tgtDir;
  logic [DUTY_W-1:0] tgtDutyA;
  logic [DUTY_W-1:0] tgtDutyB;

  assign state = curState;

  // Idle and fault hold the current direction so that stopping never triggers a reversal.
  always_comb begin
    tgtDir   = Direction;
    tgtDutyA = '0;
    tgtDutyB = '0;
    case (curState)
      FOLLOW, IR_RST: begin
        tgtDir   = lf_dir;
        tgtDutyA = lf_duty_a;
        tgtDutyB = lf_duty_b;
      end
      IR_RUN: begin
        tgtDir   = ir_dir;
        tgtDutyA = ir_duty_a;
        tgtDutyB = ir_duty_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curState       <= IDLE;
      irCnt          <= '0;
      lostCnt        <= '0;
      runCnt         <= '0;
      EnableIRModule <= 1'b0;
      ResetIRModule  <= 1'b0;
      fault          <= 1'b0;
    end else begin
      ResetIRModule <= 1'b0;
      case (curState)
        IDLE: begin
          if (start) begin
            curState <= FOLLOW;
            irCnt    <= '0;
            lostCnt  <= '0;
          end
        end
        FOLLOW: begin
          irCnt   <= IR ? irCnt + 16'd1 : '0;
          lostCnt <= (IPS == 3'b000) ? lostCnt + 16'd1 : '0;
          if (abort) begin
            curState <= IDLE;
          end else if (IR && irCnt == 16'(IR_DEBOUNCE - 1)) begin
            curState      <= IR_RST;
            ResetIRModule <= 1'b1;
            irCnt         <= '0;
          end else if (IPS == 3'b000 && lostCnt == 16'(LOST_LIMIT - 1)) begin
            curState <= FAULT;
            fault    <= 1'b1;
          end
        end
        IR_RST: begin
          if (abort) begin
            curState <= IDLE;
          end else begin
            curState       <= IR_RUN;
            EnableIRModule <= 1'b1;
            runCnt         <= '0;
          end
        end
        IR_RUN: begin
          // Done is checked before the timeout so a late finish still counts as success.
          if (abort) begin
            curState       <= IDLE;
            EnableIRModule <= 1'b0;
          end else if (IRModuleDone) begin
            curState       <= FOLLOW;
            EnableIRModule <= 1'b0;
            irCnt          <= '0;
            lostCnt        <= '0;
          end else if (runCnt == 16'(IR_TIMEOUT - 1)) begin
            curState       <= FAULT;
            EnableIRModule <= 1'b0;
            fault          <= 1'b1;
          end else begin
            runCnt <= runCnt + 16'd1;
          end
        end
        FAULT: ;
        default: curState <= IDLE;
      endcase
    end
  end

  motor_slew #(
    .RAMP_DIV   (RAMP_DIV),
    .RAMP_STEP  (RAMP_STEP),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) uSlew (
    .clk       (clk),
    .reset     (reset),
    .tgt_dir   (tgtDir),
    .tgt_duty_a(tgtDutyA),
    .tgt_duty_b(tgtDutyB),
    .Direction (Direction),
    .DutyA     (DutyA),
    .DutyB     (DutyB)
  );

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer: ramping, IR handshake, reversal dead time,
// timeout and lost-line faults, and reset behaviour.
module tb_drive_sequencer;
  import rover_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, abort, IR, IRModuleDone;
  logic [2:0]  IPS;
  logic [3:0]  lf_dir, ir_dir;
  logic [11:0] lf_duty_a, lf_duty_b, ir_duty_a, ir_duty_b;
  logic [3:0]  Direction;
  logic [11:0] DutyA, DutyB;
  logic        EnableIRModule, ResetIRModule, fault;
  logic [2:0]  state;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  drive_sequencer #(
    .IR_DEBOUNCE(4), .IR_TIMEOUT(100), .LOST_LIMIT(20),
    .RAMP_DIV(4), .RAMP_STEP(256), .DEAD_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .IPS(IPS), .IR(IR),
    .lf_dir(lf_dir), .lf_duty_a(lf_duty_a), .lf_duty_b(lf_duty_b),
    .ir_dir(ir_dir), .ir_duty_a(ir_duty_a), .ir_duty_b(ir_duty_b),
    .IRModuleDone(IRModuleDone), .Direction(Direction), .DutyA(DutyA), .DutyB(DutyB),
    .EnableIRModule(EnableIRModule), .ResetIRModule(ResetIRModule), .state(state), .fault(fault)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic startV, input logic abortV, input logic irV,
                               input logic doneV, input logic [2:0] ipsV);
    start = startV; abort = abortV; IR = irV; IRModuleDone = doneV; IPS = ipsV;
  endtask

  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDutyA(input int limit, output int waited);
    logic [11:0] prev;
    prev = DutyA;
    waited = 0;
    while (DutyA == prev && waited < limit) begin
      stepClock(1);
      waited++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time limit reached, expected run completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited, n, zeroHold, dirChanges, dutyAtChange;
    logic [3:0]  prevDir;
    logic [11:0] expA;

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 3'b010);
    lf_dir = 4'b1010; lf_duty_a = 12'd3000; lf_duty_b = 12'd1000;
    ir_dir = 4'b1010; ir_duty_a = 12'd1536; ir_duty_b = 12'd512;
    stepClock(3);
    checkOutput("rstState", state, IDLE);
    checkOutput("rstDir", Direction, 0);
    checkOutput("rstDutyA", DutyA, 0);
    checkOutput("rstDutyB", DutyB, 0);
    checkOutput("rstEnable", EnableIRModule, 0);
    checkOutput("rstResetIR", ResetIRModule, 0);
    checkOutput("rstFault", fault, 0);
    reset = 1'b0;
    stepClock(2);
    checkOutput("idleHold", state, IDLE);

    $display("[TB] Test 1: follow ramp to 3000");
    applyStimulus(1, 0, 0, 0, 3'b010);
    stepClock(1);
    applyStimulus(0, 0, 0, 0, 3'b010);
    checkOutput("startToFollow", state, FOLLOW);
    waited = 0;
    while (Direction == 4'b0000 && waited < 8) begin
      stepClock(1);
      waited++;
    end
    checkOutput("dirLoadFromStop", Direction, 4'b1010);
    checkOutput("dutyZeroAtDirLoad", DutyA, 0);
    expA = 12'd0;
    for (int i = 0; i < 12; i++) begin
      expA = (i == 11) ? 12'd3000 : expA + 12'd256;
      waitDutyA(8, waited);
      checkOutput($sformatf("rampA%0d", i), DutyA, expA);
      if (i > 0) checkOutput($sformatf("rampTick%0d", i), waited, 4);
    end
    checkOutput("rampB", DutyB, 1000);
    waitDutyA(8, waited);
    checkOutput("holdA3000", DutyA, 3000);

    lf_duty_a = 12'd1024; lf_duty_b = 12'd512;
    waited = 0;
    while (!(DutyA == 12'd1024 && DutyB == 12'd512) && waited < 60) begin
      stepClock(1);
      waited++;
    end
    checkOutput("rampDownA", DutyA, 1024);
    checkOutput("rampDownB", DutyB, 512);

    $display("[TB] Test 2: IR debounce and module reset handshake");
    applyStimulus(0, 0, 1, 0, 3'b010);
    stepClock(3);
    applyStimulus(0, 0, 0, 0, 3'b010);
    stepClock(1);
    checkOutput("irPulse3", state, FOLLOW);
    stepClock(2);
    applyStimulus(0, 0, 1, 0, 3'b010);
    stepClock(3);
    checkOutput("irDebounce3", state, FOLLOW);
    stepClock(1);
    checkOutput("irRstState", state, IR_RST);
    checkOutput("irRstPulse", ResetIRModule, 1);
    checkOutput("irRstEnable", EnableIRModule, 0);
    applyStimulus(0, 0, 0, 0, 3'b010);
    stepClock(1);
    checkOutput("irRunState", state, IR_RUN);
    checkOutput("irRstPulseEnd", ResetIRModule, 0);
    checkOutput("irRunEnable", EnableIRModule, 1);
    waitDutyA(8, waited);
    checkOutput("irTargetA", DutyA, 1280);

    $display("[TB] Test 3: reversal with dead time");
    ir_dir = 4'b0101; ir_duty_a = 12'd768; ir_duty_b = 12'd256;
    prevDir = Direction;
    zeroHold = 0; dirChanges = 0; dutyAtChange = 0;
    for (int i = 0; i < 80 && !(dirChanges > 0 && DutyA == 12'd768 && DutyB == 12'd256); i++) begin
      stepClock(1);
      if (Direction != prevDir) begin
        dirChanges++;
        if (DutyA != 12'd0 || DutyB != 12'd0) dutyAtChange++;
        prevDir = Direction;
      end else if (dirChanges == 0 && DutyA == 12'd0 && DutyB == 12'd0) begin
        zeroHold++;
      end
    end
    checkOutput("revDirChanges", dirChanges, 1);
    checkOutput("revDirection", Direction, 4'b0101);
    checkOutput("revDeadCycles", zeroHold, 8);
    checkOutput("revDutyAtChange", dutyAtChange, 0);
    checkOutput("revFinalA", DutyA, 768);
    checkOutput("revFinalB", DutyB, 256);
    checkOutput("revStillRun", state, IR_RUN);
    lf_dir = 4'b0101;
    applyStimulus(0, 0, 0, 1, 3'b010);
    stepClock(1);
    applyStimulus(0, 0, 0, 0, 3'b010);
    checkOutput("doneToFollow", state, FOLLOW);
    checkOutput("doneEnableLow", EnableIRModule, 0);

    $display("[TB] Test 4: IR run timeout");
    applyStimulus(0, 0, 1, 0, 3'b010);
    stepClock(4);
    applyStimulus(0, 0, 0, 0, 3'b010);
    checkOutput("irReenter", state, IR_RST);
    stepClock(1);
    n = 0;
    while (state == IR_RUN && n < 150) begin
      n++;
      stepClock(1);
    end
    checkOutput("timeoutCycles", n, 100);
    checkOutput("timeoutState", state, FAULT);
    checkOutput("timeoutFault", fault, 1);
    checkOutput("timeoutEnable", EnableIRModule, 0);
    waited = 0;
    while ((DutyA != 12'd0 || DutyB != 12'd0) && waited < 40) begin
      stepClock(1);
      waited++;
    end
    checkOutput("faultDutyA", DutyA, 0);
    checkOutput("faultDutyB", DutyB, 0);
    checkOutput("faultDirHeld", Direction, 4'b0101);

    reset = 1'b1;
    stepClock(1);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 3'b010);
    stepClock(1);
    applyStimulus(0, 0, 1, 0, 3'b010);
    stepClock(4);
    applyStimulus(0, 0, 0, 0, 3'b010);
    stepClock(1);
    checkOutput("variantRun", state, IR_RUN);
    stepClock(99);
    checkOutput("variantRunAt100", state, IR_RUN);
    applyStimulus(0, 0, 0, 1, 3'b010);
    stepClock(1);
    applyStimulus(0, 0, 0, 0, 3'b010);
    checkOutput("doneWinsState", state, FOLLOW);
    checkOutput("doneWinsFault", fault, 0);

    $display("[TB] Test 5: lost line");
    applyStimulus(0, 0, 0, 0, 3'b000);
    stepClock(19);
    checkOutput("lost19", state, FOLLOW);
    applyStimulus(0, 0, 0, 0, 3'b001);
    stepClock(1);
    checkOutput("lostRecover", state, FOLLOW);
    applyStimulus(0, 0, 0, 0, 3'b000);
    stepClock(19);
    checkOutput("lost19Again", state, FOLLOW);
    stepClock(1);
    checkOutput("lost20", state, FAULT);
    applyStimulus(1, 0, 0, 0, 3'b010);
    stepClock(1);
    checkOutput("faultIgnStart", state, FAULT);
    applyStimulus(0, 1, 0, 0, 3'b010);
    stepClock(2);
    checkOutput("faultIgnAbort", state, FAULT);
    checkOutput("faultFlag", fault, 1);
    applyStimulus(0, 0, 0, 0, 3'b010);

    $display("[TB] Test 6: reset mid-ramp and abort");
    reset = 1'b1;
    stepClock(1);
    reset = 1'b0;
    lf_dir = 4'b1010; lf_duty_a = 12'd3000; lf_duty_b = 12'd1000;
    applyStimulus(1, 0, 0, 0, 3'b010);
    stepClock(1);
    applyStimulus(0, 0, 0, 0, 3'b010);
    waited = 0;
    while (DutyA != 12'd1024 && waited < 40) begin
      stepClock(1);
      waited++;
    end
    checkOutput("midRampA", DutyA, 1024);
    reset = 1'b1;
    stepClock(1);
    checkOutput("midRstDutyA", DutyA, 0);
    checkOutput("midRstDutyB", DutyB, 0);
    checkOutput("midRstDir", Direction, 0);
    checkOutput("midRstState", state, IDLE);
    checkOutput("midRstFault", fault, 0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 3'b010);
    stepClock(1);
    applyStimulus(0, 0, 1, 0, 3'b010);
    stepClock(4);
    applyStimulus(0, 0, 0, 0, 3'b010);
    stepClock(1);
    checkOutput("abortPreEnable", EnableIRModule, 1);
    applyStimulus(0, 1, 0, 0, 3'b010);
    stepClock(1);
    applyStimulus(0, 0, 0, 0, 3'b010);
    checkOutput("abortState", state, IDLE);
    checkOutput("abortEnable", EnableIRModule, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
